// File: rtl/loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : loader_pkg
// Description : Shared types and constants for the cpu program loader.
// Revision    : 1.0 - initial release
// ============================================================================
package loader_pkg;

    localparam logic [7:0] HDR_BYTE  = 8'hA5;
    localparam int         MEM_DEPTH = 32;
    localparam int         MAX_LEN   = 32;
    localparam int         CNT_W     = $clog2(MAX_LEN + 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CNT  = 3'd1,
        ADR  = 3'd2,
        DAT  = 3'd3,
        CHK  = 3'd4,
        RUN  = 3'd5,
        ERR  = 3'd6
    } ldr_state_e;

    // Instruction opcodes of the cpu fed by this loader (upper 3 bits of a byte).
    typedef enum logic [2:0] {
        HLT = 3'd0,
        SKZ = 3'd1,
        ADD = 3'd2,
        AND = 3'd3,
        XOR = 3'd4,
        LDA = 3'd5,
        STO = 3'd6,
        JMP = 3'd7
    } opcode_e;

    function automatic logic is_busy(input ldr_state_e s);
        return (s == CNT) || (s == ADR) || (s == DAT) || (s == CHK);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : cpu_prog_loader
// Description : Framed byte-stream boot loader writing the cpu memory load
//               port and gating cpu reset on a good XOR checksum.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_prog_loader
    import loader_pkg::*;
#(
    parameter int                ADDR_W = 5,
    parameter int                DATA_W = 8,
    parameter logic [DATA_W-1:0] HDR    = HDR_BYTE
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wr,
    output logic              cpu_rst_,
    input  logic              halt,
    output logic              busy,
    output logic              load_ok,
    output logic              load_err,
    output logic              run_done
);

    ldr_state_e        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_acc;

    ldr_state_e        w_nxt_state;
    logic [CNT_W-1:0]  w_nxt_cnt;
    logic [ADDR_W-1:0] w_nxt_addr;
    logic [DATA_W-1:0] w_nxt_acc;
    logic [ADDR_W-1:0] w_nxt_mem_addr;
    logic [DATA_W-1:0] w_nxt_mem_data;
    logic              w_nxt_mem_wr;
    logic              w_nxt_cpu_rst_;
    logic              w_nxt_load_ok;
    logic              w_nxt_load_err;
    logic              w_nxt_run_done;
    logic              w_accept;
    logic              w_restart;

    assign in_ready  = 1'b1;
    assign w_accept  = in_valid;
    // HDR only resynchronises outside a frame; inside a frame it is plain data.
    assign w_restart = w_accept && (in_data == HDR) &&
                       ((r_state == IDLE) || (r_state == RUN) || (r_state == ERR));

    always_comb begin
        w_nxt_state    = r_state;
        w_nxt_cnt      = r_cnt;
        w_nxt_addr     = r_addr;
        w_nxt_acc      = r_acc;
        w_nxt_mem_addr = mem_addr;
        w_nxt_mem_data = mem_data;
        w_nxt_mem_wr   = 1'b0;
        w_nxt_cpu_rst_ = cpu_rst_;
        w_nxt_load_ok  = 1'b0;
        w_nxt_load_err = load_err;
        w_nxt_run_done = run_done;

        if (w_restart) begin
            w_nxt_state    = CNT;
            w_nxt_cpu_rst_ = 1'b0;
            w_nxt_load_err = 1'b0;
            w_nxt_run_done = 1'b0;
        end else begin
            case (r_state)
                IDLE: ;
                CNT: if (w_accept) begin
                    if ((in_data == '0) || (in_data > DATA_W'(MAX_LEN))) begin
                        w_nxt_state    = ERR;
                        w_nxt_load_err = 1'b1;
                    end else begin
                        w_nxt_cnt   = CNT_W'(in_data);
                        w_nxt_state = ADR;
                    end
                end
                ADR: if (w_accept) begin
                    w_nxt_addr  = in_data[ADDR_W-1:0];
                    w_nxt_acc   = '0;
                    w_nxt_state = DAT;
                end
                DAT: if (w_accept) begin
                    w_nxt_mem_wr   = 1'b1;
                    w_nxt_mem_addr = r_addr;
                    w_nxt_mem_data = in_data;
                    w_nxt_addr     = r_addr + 1'b1;
                    w_nxt_acc      = r_acc ^ in_data;
                    w_nxt_cnt      = r_cnt - 1'b1;
                    if (r_cnt == CNT_W'(1))
                        w_nxt_state = CHK;
                end
                CHK: if (w_accept) begin
                    if (in_data == r_acc) begin
                        w_nxt_state    = RUN;
                        w_nxt_load_ok  = 1'b1;
                        w_nxt_cpu_rst_ = 1'b1;
                    end else begin
                        w_nxt_state    = ERR;
                        w_nxt_load_err = 1'b1;
                    end
                end
                RUN: if (halt) w_nxt_run_done = 1'b1;
                ERR: ;
                default: w_nxt_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_addr   <= '0;
            r_acc    <= '0;
            mem_addr <= '0;
            mem_data <= '0;
            mem_wr   <= 1'b0;
            cpu_rst_ <= 1'b0;
            busy     <= 1'b0;
            load_ok  <= 1'b0;
            load_err <= 1'b0;
            run_done <= 1'b0;
        end else begin
            r_state  <= w_nxt_state;
            r_cnt    <= w_nxt_cnt;
            r_addr   <= w_nxt_addr;
            r_acc    <= w_nxt_acc;
            mem_addr <= w_nxt_mem_addr;
            mem_data <= w_nxt_mem_data;
            mem_wr   <= w_nxt_mem_wr;
            cpu_rst_ <= w_nxt_cpu_rst_;
            busy     <= is_busy(w_nxt_state);
            load_ok  <= w_nxt_load_ok;
            load_err <= w_nxt_load_err;
            run_done <= w_nxt_run_done;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_prog_loader
// Description : Directed bench for cpu_prog_loader with a small behavioural
//               cpu and 32x8 memory on the load port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_prog_loader;
    import loader_pkg::*;

    localparam logic [7:0] c_lda_1c = {LDA, 5'h1C};
    localparam logic [7:0] c_sto_1a = {STO, 5'h1A};
    localparam logic [7:0] c_sto_1b = {STO, 5'h1B};
    localparam logic [7:0] c_jmp_05 = {JMP, 5'h05};
    localparam logic [7:0] c_hlt    = {HLT, 5'h00};

    logic       clk = 1'b0;
    logic       rst_;
    logic       in_valid;
    logic [7:0] in_data;
    wire        in_ready;
    wire  [4:0] mem_addr;
    wire  [7:0] mem_data;
    wire        mem_wr;
    wire        cpu_rst_;
    logic       halt;
    wire        busy;
    wire        load_ok;
    wire        load_err;
    wire        run_done;

    always #5 clk = ~clk;

    cpu_prog_loader #(.ADDR_W(5), .DATA_W(8), .HDR(8'hA5)) dut (
        .clk(clk), .rst_(rst_), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_wr(mem_wr), .cpu_rst_(cpu_rst_), .halt(halt), .busy(busy),
        .load_ok(load_ok), .load_err(load_err), .run_done(run_done)
    );

    // Behavioural cpu: one instruction per cycle while out of reset.
    logic [7:0] mem [0:31];
    logic [4:0] pc;
    logic [7:0] acc;
    logic       init_mem;
    int         wr_count = 0;
    logic [4:0] wr_a [0:255];
    logic [7:0] wr_d [0:255];
    wire  [7:0] w_ir = mem[pc];
    opcode_e    w_op;
    assign w_op = opcode_e'(w_ir[7:5]);

    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 32; i++) mem[i] <= (i == 28) ? 8'h05 : 8'h00;
        end else if (mem_wr) begin
            mem[mem_addr] <= mem_data;
        end
        if (mem_wr) begin
            wr_a[wr_count[7:0]] <= mem_addr;
            wr_d[wr_count[7:0]] <= mem_data;
            wr_count <= wr_count + 1;
        end
        if (!cpu_rst_) begin
            pc <= 5'd0; acc <= 8'd0; halt <= 1'b0;
        end else if (!halt) begin
            case (w_op)
                HLT: halt <= 1'b1;
                SKZ: pc <= pc + ((acc == 8'h00) ? 5'd2 : 5'd1);
                ADD: begin acc <= acc + mem[w_ir[4:0]]; pc <= pc + 5'd1; end
                AND: begin acc <= acc & mem[w_ir[4:0]]; pc <= pc + 5'd1; end
                XOR: begin acc <= acc ^ mem[w_ir[4:0]]; pc <= pc + 5'd1; end
                LDA: begin acc <= mem[w_ir[4:0]]; pc <= pc + 5'd1; end
                STO: begin mem[w_ir[4:0]] <= acc; pc <= pc + 5'd1; end
                JMP: pc <= w_ir[4:0];
                default: pc <= pc + 5'd1;
            endcase
        end
    end

    int n_vec = 0;
    int n_err = 0;
    int wr_base;
    logic [7:0] q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_q();
        foreach (q[i]) send(q[i]);
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 40 && !run_done; i++) begin
            @(posedge clk);
            #1;
        end
        chk(tag, {31'd0, run_done}, 32'd1);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ready"},    {31'd0, in_ready}, 32'd1);
        chk({tag, "_mem"},      {18'd0, mem_wr, mem_addr, mem_data}, 32'd0);
        chk({tag, "_cpu_rst_"}, {31'd0, cpu_rst_}, 32'd0);
        chk({tag, "_flags"},    {28'd0, busy, load_ok, load_err, run_done}, 32'd0);
    endtask

    initial begin
        rst_ = 1'b0; in_valid = 1'b0; in_data = 8'h00; init_mem = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_reset("reset");
        @(negedge clk);
        init_mem = 1'b0; rst_ = 1'b1;

        // Basic load: LDA 1C; STO 1A; HLT
        send(8'hA5);
        chk("hdr_busy", {31'd0, busy}, 32'd1);
        send(8'h03); send(8'h00);
        send(c_lda_1c);
        chk("wr0", {18'd0, mem_wr, mem_addr, mem_data}, {18'd0, 1'b1, 5'h00, 8'hBC});
        send(c_sto_1a);
        chk("wr1", {18'd0, mem_wr, mem_addr, mem_data}, {18'd0, 1'b1, 5'h01, 8'hDA});
        send(c_hlt);
        chk("wr2", {18'd0, mem_wr, mem_addr, mem_data}, {18'd0, 1'b1, 5'h02, 8'h00});
        chk("pre_chk_cpu_rst_", {30'd0, cpu_rst_, busy}, {30'd0, 1'b0, 1'b1});
        send(8'h66);
        chk("chk_ok", {28'd0, load_ok, cpu_rst_, busy, mem_wr}, {28'd0, 4'b1100});
        @(posedge clk); #1;
        chk("ok_pulse_end", {31'd0, load_ok}, 32'd0);
        wait_done("run1_done");
        chk("run1_sto", {24'd0, mem[26]}, 32'h05);
        chk("run1_pc",  {27'd0, pc}, 32'd2);

        // Reload while running
        send(8'hA5);
        chk("reload_hdr", {29'd0, cpu_rst_, run_done, busy}, {29'd0, 3'b001});
        q = {8'h06, 8'h00, c_lda_1c, c_sto_1b, c_jmp_05, 8'h00, 8'h00, c_hlt, 8'h82};
        send_q();
        chk("reload_ok", {30'd0, load_ok, cpu_rst_}, {30'd0, 2'b11});
        wait_done("run2_done");
        chk("run2_pc",  {27'd0, pc}, 32'd5);
        chk("run2_sto", {24'd0, mem[27]}, 32'h05);

        // Address wrap 1E,1F,00,01; checksum 11^22^33^44 = 44
        wr_base = wr_count;
        q = {8'hA5, 8'h04, 8'h1E, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
        send_q();
        chk("wrap_ok", {31'd0, load_ok}, 32'd1);
        chk("wrap_n",  wr_count - wr_base, 32'd4);
        chk("wrap_w0", {19'd0, wr_a[wr_base[7:0]],   wr_d[wr_base[7:0]]},   {19'd0, 5'h1E, 8'h11});
        chk("wrap_w1", {19'd0, wr_a[wr_base[7:0]+1], wr_d[wr_base[7:0]+1]}, {19'd0, 5'h1F, 8'h22});
        chk("wrap_w2", {19'd0, wr_a[wr_base[7:0]+2], wr_d[wr_base[7:0]+2]}, {19'd0, 5'h00, 8'h33});
        chk("wrap_w3", {19'd0, wr_a[wr_base[7:0]+3], wr_d[wr_base[7:0]+3]}, {19'd0, 5'h01, 8'h44});
        chk("wrap_keep", {16'd0, mem[2], mem[28]}, {16'd0, 8'hE5, 8'h05});
        wait_done("wrap_done");
        chk("wrap_pc", {27'd0, pc}, 32'd5);

        // Bad checksum, then recovery
        q = {8'hA5, 8'h02, 8'h00, 8'h01, 8'h02, 8'h00};
        send_q();
        chk("badchk", {28'd0, load_err, load_ok, cpu_rst_, busy}, {28'd0, 4'b1000});
        repeat (3) @(posedge clk);
        #1;
        chk("badchk_hold", {30'd0, load_err, cpu_rst_}, {30'd0, 2'b10});
        send(8'hA5);
        chk("recover_hdr", {30'd0, load_err, busy}, {30'd0, 2'b01});
        q = {8'h03, 8'h00, c_lda_1c, c_sto_1a, c_hlt, 8'h66};
        send_q();
        chk("recover_ok", {30'd0, load_ok, cpu_rst_}, {30'd0, 2'b11});
        wait_done("recover_done");

        // Bad counts 0 and 33
        wr_base = wr_count;
        send(8'hA5); send(8'h00);
        chk("cnt0", {29'd0, load_err, cpu_rst_, busy}, {29'd0, 3'b100});
        send(8'hA5);
        chk("cnt_hdr_clr", {31'd0, load_err}, 32'd0);
        send(8'h21);
        chk("cnt33", {29'd0, load_err, cpu_rst_, busy}, {29'd0, 3'b100});
        chk("cnt_no_wr", wr_count - wr_base, 32'd0);

        // Reset after 2 of 5 data bytes
        q = {8'hA5, 8'h05, 8'h00, 8'h01, 8'h02};
        send_q();
        chk("mid_wr", {31'd0, mem_wr}, 32'd1);
        @(negedge clk); rst_ = 1'b0;
        @(posedge clk); #1;
        chk_reset("midrst");
        @(negedge clk); rst_ = 1'b1;
        wr_base = wr_count;
        q = {8'h03, 8'h04, 8'h05, 8'h00};
        send_q();
        chk("midrst_discard", {wr_count - wr_base} + {31'd0, busy}, 32'd0);
        send(8'hA5);
        chk("midrst_hdr", {31'd0, busy}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
